// File: rtl/cpc_io_decode_pkg.sv
// Shared definitions for the CPC gate-array I/O write decoder: FSM encoding,
// port-class codes carried in data[7:6], and the I/O-write qualification rule.
package cpc_io_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SAMPLE = 2'b01,
    ST_HOLD   = 2'b10
  } io_state_e;

  localparam logic [1:0] PORT_CLASS_RAM = 2'b11;
  localparam logic [1:0] PORT_CLASS_ROM = 2'b10;

  localparam int RAMCFG_W = 7;
  localparam int ROMCFG_W = 2;

  // Interrupt acknowledge drives iorq_b low with m1_b low; it must never count
  // as a port write, hence the explicit m1_b term.
  function automatic logic io_write_qualify(
    input logic iorq_b,
    input logic wr_b,
    input logic m1_b,
    input logic adr15
  );
    return !iorq_b && !wr_b && m1_b && !adr15;
  endfunction

endpackage

// File: rtl/cpc_io_decode.sv
// Decodes Z80 OUT cycles to the gate array into RAM and ROM configuration
// registers, with a two-sample glitch filter and one capture per I/O cycle.
module cpc_io_decode
  import cpc_io_decode_pkg::*;
(
  input  logic                clk,
  input  logic                reset_b,
  input  logic                iorq_b,
  input  logic                wr_b,
  input  logic                m1_b,
  input  logic                adr15,
  input  logic                adr8,
  input  logic [7:0]          data,
  output logic [RAMCFG_W-1:0] ramcfg_q,
  output logic                ramcfg_stb,
  output logic                ramcfg_chg,
  output logic [ROMCFG_W-1:0] romcfg_q,
  output logic                romcfg_stb,
  output logic                busy
);

  io_state_e           state_q, state_d;
  logic [RAMCFG_W-1:0] ramcfg_d;
  logic [ROMCFG_W-1:0] romcfg_d;
  logic                ramcfg_stb_q, ramcfg_stb_d;
  logic                ramcfg_chg_q, ramcfg_chg_d;
  logic                romcfg_stb_q, romcfg_stb_d;
  logic                busy_q, busy_d;
  logic                qualify;
  logic [RAMCFG_W-1:0] ramcfg_new;

  assign qualify    = io_write_qualify(iorq_b, wr_b, m1_b, adr15);
  assign ramcfg_new = {adr8, data[5:0]};

  always_comb begin
    state_d      = state_q;
    ramcfg_d     = ramcfg_q;
    romcfg_d     = romcfg_q;
    ramcfg_stb_d = 1'b0;
    ramcfg_chg_d = 1'b0;
    romcfg_stb_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (qualify) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (qualify) begin
          // Second consecutive qualified sample: commit using this edge's bus.
          state_d = ST_HOLD;
          if (data[7:6] == PORT_CLASS_RAM) begin
            ramcfg_d     = ramcfg_new;
            ramcfg_stb_d = 1'b1;
            ramcfg_chg_d = (ramcfg_new != ramcfg_q);
          end else if (data[7:6] == PORT_CLASS_ROM) begin
            romcfg_d     = data[3:2];
            romcfg_stb_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (iorq_b) state_d = ST_IDLE;
      end
      default: begin
        // Unused encoding: wait for the bus to go quiet like after reset.
        state_d = ST_HOLD;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q      <= ST_HOLD;
      ramcfg_q     <= '0;
      romcfg_q     <= '0;
      ramcfg_stb_q <= 1'b0;
      ramcfg_chg_q <= 1'b0;
      romcfg_stb_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ramcfg_q     <= ramcfg_d;
      romcfg_q     <= romcfg_d;
      ramcfg_stb_q <= ramcfg_stb_d;
      ramcfg_chg_q <= ramcfg_chg_d;
      romcfg_stb_q <= romcfg_stb_d;
      busy_q       <= busy_d;
    end
  end

  assign ramcfg_stb = ramcfg_stb_q;
  assign ramcfg_chg = ramcfg_chg_q;
  assign romcfg_stb = romcfg_stb_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cpc_io_decode.sv
// Directed and randomized OUT-cycle stimulus against a transaction-level model
// of the CPC gate-array configuration writes.
`timescale 1ns/1ps
module tb_cpc_io_decode;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       iorq_b, wr_b, m1_b, adr15, adr8;
  logic [7:0] data;
  logic [6:0] ramcfg_q;
  logic       ramcfg_stb, ramcfg_chg;
  logic [1:0] romcfg_q;
  logic       romcfg_stb, busy;

  int vectors     = 0;
  int miscompares = 0;
  int txn_no      = 0;

  logic [6:0] model_ram;
  logic [1:0] model_rom;

  always #125 clk = ~clk;

  cpc_io_decode dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .iorq_b     (iorq_b),
    .wr_b       (wr_b),
    .m1_b       (m1_b),
    .adr15      (adr15),
    .adr8       (adr8),
    .data       (data),
    .ramcfg_q   (ramcfg_q),
    .ramcfg_stb (ramcfg_stb),
    .ramcfg_chg (ramcfg_chg),
    .romcfg_q   (romcfg_q),
    .romcfg_stb (romcfg_stb),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    iorq_b = 1'b1;
    wr_b   = 1'b1;
    m1_b   = 1'b1;
  endtask

  // One bus cycle: iorq_b low for len edges with constant strobes/data,
  // then iorq_b high for gap edges. Expectations come from the transaction rule:
  // a qualified write lasting at least two edges is captured exactly once,
  // and its strobe is visible right after the second low edge.
  task automatic do_io(input string tag, input logic [7:0] d, input logic a8,
                       input logic a15, input logic m1, input logic wr,
                       input int len, input int gap);
    int ram_n, rom_n, chg_n, both_n, first_stb;
    int exp_ram_n, exp_rom_n, exp_chg_n;
    logic cap;
    logic [6:0] nv;
    ram_n = 0; rom_n = 0; chg_n = 0; both_n = 0; first_stb = 0;
    exp_ram_n = 0; exp_rom_n = 0; exp_chg_n = 0;

    cap = !wr && m1 && !a15 && (len >= 2);
    nv  = {a8, d[5:0]};
    if (cap && d[7:6] == 2'b11) begin
      exp_ram_n = 1;
      exp_chg_n = (nv != model_ram) ? 1 : 0;
      model_ram = nv;
    end else if (cap && d[7:6] == 2'b10) begin
      exp_rom_n = 1;
      model_rom = d[3:2];
    end

    data = d; adr8 = a8; adr15 = a15; m1_b = m1; wr_b = wr; iorq_b = 1'b0;
    for (int e = 1; e <= len + gap; e++) begin
      if (e == len + 1) bus_idle();
      step();
      if (ramcfg_stb) begin
        ram_n++;
        if (first_stb == 0) first_stb = e;
      end
      if (romcfg_stb) begin
        rom_n++;
        if (first_stb == 0) first_stb = e;
      end
      if (ramcfg_chg) chg_n++;
      if (ramcfg_stb && romcfg_stb) both_n++;
    end

    txn_no++;
    $display("txn %0d %s: data=%02h a8=%0b a15=%0b m1_b=%0b wr_b=%0b len=%0d gap=%0d -> ram=%02h rom=%0b stb=%0d/%0d chg=%0d",
             txn_no, tag, d, a8, a15, m1, wr, len, gap, ramcfg_q, romcfg_q, ram_n, rom_n, chg_n);

    check({tag, ".ram_stb_cnt"}, ram_n, exp_ram_n);
    check({tag, ".rom_stb_cnt"}, rom_n, exp_rom_n);
    check({tag, ".chg_cnt"}, chg_n, exp_chg_n);
    check({tag, ".both_stb"}, both_n, 0);
    if (exp_ram_n + exp_rom_n > 0) check({tag, ".stb_edge"}, first_stb, 2);
    check({tag, ".ramcfg"}, ramcfg_q, model_ram);
    check({tag, ".romcfg"}, romcfg_q, model_rom);
    check({tag, ".busy_end"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] rd, last_d;
    logic       ra8, last_a8;

    reset_b = 1'b0;
    bus_idle();
    adr15 = 1'b0; adr8 = 1'b0; data = 8'h00;
    model_ram = '0; model_rom = '0;

    step(); step();
    check("rst.ramcfg", ramcfg_q, 7'h00);
    check("rst.romcfg", romcfg_q, 2'b00);
    check("rst.ram_stb", ramcfg_stb, 1'b0);
    check("rst.chg", ramcfg_chg, 1'b0);
    check("rst.rom_stb", romcfg_stb, 1'b0);
    check("rst.busy", busy, 1'b1);
    reset_b = 1'b1;
    step();
    check("rst.idle", busy, 1'b0);

    do_io("ram_c4", 8'hC4, 1'b1, 1'b0, 1'b1, 1'b0, 4, 2);
    check("ram_c4.val", ramcfg_q, 7'h44);
    do_io("ram_c4_again", 8'hC4, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1);
    do_io("ram_c7", 8'hC7, 1'b0, 1'b0, 1'b1, 1'b0, 4, 2);
    check("ram_c7.val", ramcfg_q, 7'h07);
    do_io("rom_8c", 8'h8C, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1);
    check("rom_8c.val", romcfg_q, 2'b11);
    check("rom_8c.ram_kept", ramcfg_q, 7'h07);
    do_io("ign_40", 8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1);
    do_io("glitch", 8'hC1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2);
    do_io("int_ack", 8'hC2, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1);
    do_io("a15_hi", 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 4, 1);

    // Reset landing in SAMPLE with the write still pending must not capture,
    // and release during the same I/O cycle must not capture either.
    data = 8'hC5; adr8 = 1'b1; adr15 = 1'b0; m1_b = 1'b1; wr_b = 1'b0; iorq_b = 1'b0;
    step();
    reset_b = 1'b0;
    step();
    model_ram = '0; model_rom = '0;
    check("midrst.ram_stb", ramcfg_stb, 1'b0);
    check("midrst.ramcfg", ramcfg_q, 7'h00);
    check("midrst.busy", busy, 1'b1);
    reset_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("relrst.ram_stb", ramcfg_stb, 1'b0);
      check("relrst.busy", busy, 1'b1);
    end
    check("relrst.ramcfg", ramcfg_q, 7'h00);
    bus_idle();
    step();
    check("relrst.idle", busy, 1'b0);
    do_io("ram_c5", 8'hC5, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1);
    check("ram_c5.val", ramcfg_q, 7'h45);

    last_d = 8'hC5; last_a8 = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(3) == 0) begin
        rd = last_d; ra8 = last_a8;
      end else begin
        rd = 8'($urandom); ra8 = 1'($urandom);
      end
      do_io("rand", rd, ra8,
            ($urandom_range(3) == 0), ($urandom_range(4) != 0), ($urandom_range(4) == 0),
            int'($urandom_range(5, 1)), int'($urandom_range(3, 1)));
      last_d = rd; last_a8 = ra8;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpc_io_decode.md
CPC_IO_DECODE -- requirements
Module: cpc_io_decode

Interface
REQ-001 SHALL have ports: clk, input, 1, CPU clock (4 MHz); all state updates on rising edge.
REQ-002 SHALL have ports: reset_b, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have ports: iorq_b, wr_b, m1_b, input, 1 each, Z80 bus strobes, active-low.
REQ-004 SHALL have ports: adr15, adr8, input, 1 each, CPU address bits.
REQ-005 SHALL have port: data, input, 8, CPU data bus.
REQ-006 SHALL have outputs: ramcfg_q, 7, last RAM config {adr8,data[5:0]}; ramcfg_stb, 1, one-clock pulse on RAM config capture; ramcfg_chg, 1, one-clock pulse when captured value differs from previous.
REQ-007 SHALL have outputs: romcfg_q, 2, {urom_disable,lrom_disable}; romcfg_stb, 1, one-clock pulse on ROM config capture.
REQ-008 SHALL have output: busy, 1, high while state is not IDLE.

Function
REQ-009 SHALL qualify an I/O write as iorq_b=0, wr_b=0, m1_b=1, adr15=0; interrupt acknowledge (iorq_b=0, m1_b=0) SHALL never qualify.
REQ-010 SHALL classify by data[7:6]: 11 = RAM config, 10 = ROM config, 0x = ignored (no strobe, no register change).
REQ-011 SHALL implement FSM states IDLE, SAMPLE, HOLD.
REQ-012 IDLE -> SAMPLE when qualify true at a rising edge; otherwise stay IDLE.
REQ-013 SAMPLE -> HOLD, with capture, when qualify still true on the next edge (two-sample glitch filter); SAMPLE -> IDLE, no capture, if qualify false.
REQ-014 HOLD -> IDLE only when iorq_b=1 is sampled; exactly one capture per I/O cycle regardless of its length.
REQ-015 Capture SHALL use bus values sampled on the SAMPLE->HOLD edge; outputs update one clock later (latency: strobe high in the first HOLD cycle).
REQ-016 RAM capture SHALL load ramcfg_q <= {adr8,data[5:0]} and assert ramcfg_stb for exactly one clock.
REQ-017 ramcfg_chg SHALL assert with ramcfg_stb only if new ramcfg_q differs from its prior value; rewrite of same value gives stb only.
REQ-018 ROM capture SHALL load romcfg_q <= data[3:2] and assert romcfg_stb for one clock; ramcfg_q unaffected, and vice versa.
REQ-019 Strobes SHALL never assert simultaneously; an ignored-class write passes SAMPLE->HOLD with no strobe.
REQ-020 Back-to-back I/O writes SHALL each be captured provided iorq_b returns high for at least one sampled edge between them.

Reset
REQ-021 On reset_b=0 at a rising edge: ramcfg_q=0, romcfg_q=0, all strobes 0, state=HOLD (busy=1).
REQ-022 Entering HOLD on reset SHALL suppress capture of any I/O cycle already in progress when reset is released; state reaches IDLE only after iorq_b=1 is sampled.
REQ-023 Reset asserted mid-cycle (SAMPLE or HOLD) SHALL abort without capture or strobe.

Structure
REQ-024 Shared package SHALL hold FSM state encoding and constants PORT_CLASS_RAM=2'b11, PORT_CLASS_ROM=2'b10.
REQ-025 Single module, no sub-modules; outputs feed the RAM-expansion decode stage directly.

Verification
REQ-026 Reset, then OUT (&7FFF),&C4 held 4 clocks -> ramcfg_q=7'h44, ramcfg_stb and ramcfg_chg one pulse each in the first HOLD cycle.
REQ-027 Repeat &C4 write -> ramcfg_stb pulse, ramcfg_chg stays 0; then OUT (&7EFF),&C7 -> ramcfg_q=7'h07, chg pulses.
REQ-028 OUT (&7FFF),&8C -> romcfg_q=2'b11, romcfg_stb one pulse, ramcfg_q unchanged; OUT &7FFF,&40 -> no strobe.
REQ-029 iorq_b/wr_b low for a single sampled edge, and iorq_b=0 with m1_b=0 -> no capture, no strobe, FSM back to IDLE.
REQ-030 Release reset while iorq_b=0, wr_b=0, data=&C5 -> no capture; after iorq_b high then a new &C5 write -> ramcfg_q=7'h45.
